// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - fetch/data/memory bus bundle for the MIPS unified-memory arbiter
//
// Signals:
//   if_req/if_addr -> if_ready/if_rdata       instruction-fetch request and response
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata  load/store request and response
//   mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata  single-ported memory side
//   stall                                     datapath hold
// Modports:
//   slave  - arbiter view (consumes requests, drives memory strobes)
//   master - processor/memory-model view
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one single-ported memory between MIPS fetch and data paths
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - mips_mem_arbiter_if.slave: fetch/data request-response pairs,
//            memory strobe/address/data, and the stall flag
// Parameters:
//   ADDR_W  - address width
//   MEM_LAT - cycles from the mem_en cycle to valid mem_rdata (1..15)
module mips_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic               clk,
    input logic               reset,
    mips_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    logic              last_grant;   // 0 = fetch won last, 1 = data won last
    logic              sel;          // side owning the in-flight transaction
    logic              we_q;
    logic [3:0]        wait_cnt;

    logic              if_ready_q;
    logic              d_ready_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              grant_d;

    // Data wins when it is alone, or when both request and fetch won last time.
    always_comb begin
        grant_d = bus.d_req & (~bus.if_req | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b0;
            sel         <= 1'b0;
            we_q        <= 1'b0;
            wait_cnt    <= 4'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        sel        <= grant_d;
                        last_grant <= grant_d;
                        we_q       <= grant_d & bus.d_we;
                        // Strobes are registered so they are high exactly during ISSUE.
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= grant_d & bus.d_we;
                        mem_addr_q <= grant_d ? bus.d_addr : bus.if_addr;
                        if (grant_d) begin
                            mem_wdata_q <= bus.d_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    wait_cnt <= 4'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        // Final WAIT cycle is the one where mem_rdata is valid.
                        if (!we_q) begin
                            if (sel) begin
                                d_rdata_q <= bus.mem_rdata;
                            end else begin
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end
                        if (sel) begin
                            d_ready_q <= 1'b1;
                        end else begin
                            if_ready_q <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // No grant here, so a request still high during ready is not re-served.
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.d_req & ~d_ready_q);

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Sequences one single-ported unified memory and shares it between the instruction-fetch path (PC side) and the data-access path (load/store side) of the single-cycle MIPS processor.
- Each transaction runs through an issue/wait/done state machine.
- Fetch/data conflicts are arbitrated by alternating priority.
- Emits a stall flag so the PC counter and register-file write are held while an access is outstanding.

Parameters:
- ADDR_W, 32, memory address width in bits.
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ready is seen.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  32  fetched instruction word.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ready is seen.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle pulse; load data valid / store complete.
- d_rdata  out  32  load data.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- stall  out  1  datapath hold.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Registers: last_grant (0 = fetch, 1 = data), sel, we_q, wait counter.
- Reset values: state=IDLE, last_grant=0, sel=0. All outputs are 0: if_ready, d_ready, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata.
- IDLE (cycle T), grant selection:
  - Only d_req high -> grant data.
  - Only if_req high -> grant fetch.
  - Both high -> grant the side opposite to last_grant. The first conflict after reset therefore goes to data.
- On a grant:
  - Latch sel, we_q, mem_addr and mem_wdata from the winner.
  - Update last_grant and go to ISSUE.
  - For a fetch grant, mem_wdata is held and we_q=0.
- No request in IDLE -> stay in IDLE.
- ISSUE (T+1):
  - mem_en=1, mem_we=we_q.
  - Load the counter with MEM_LAT-1 and go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles (T+2 .. T+1+MEM_LAT).
  - On the final WAIT edge, if we_q=0, capture mem_rdata into if_rdata (sel=0) or d_rdata (sel=1).
  - Then go to DONE.
- DONE (T+2+MEM_LAT):
  - Assert if_ready (sel=0) or d_ready (sel=1) for exactly one cycle; go to IDLE.
  - A request is never granted in DONE, so a req still high during the ready cycle is not re-granted.
- Timing:
  - Latency from grant to ready is MEM_LAT+2 cycles.
  - Minimum spacing between grants is MEM_LAT+3 cycles.
- Stores: d_ready pulses in DONE as a write acknowledge; d_rdata is unchanged.
- Hold rules:
  - if_rdata and d_rdata hold their last value between transactions.
  - mem_addr and mem_wdata hold between transactions.
  - mem_en=0 and mem_we=0 in every state except ISSUE.
- stall (combinational): (if_req & ~if_ready) | (d_req & ~d_ready).
- Requests arriving while not in IDLE:
  - They are not lost; they are evaluated at the next IDLE.
  - The losing side keeps its request pending; alternation guarantees a grant within one transaction.
- Request drop: deasserting a req before its ready is a protocol violation. The in-flight transaction still completes and still pulses ready.
- Reset mid-transaction: abandon the transaction with no ready pulse. Next cycle is IDLE with all outputs 0 and last_grant=0.
- Addresses and data pass through unmodified; no alignment checking.

Test Plan:
- Fetch only, MEM_LAT=2, if_req=1 and if_addr=0x00000040 at cycle 0, mem_rdata=0x8C010004 at cycle 3:
  - mem_en=1, mem_we=0, mem_addr=0x40 at cycle 1.
  - if_ready=1 and if_rdata=0x8C010004 at cycle 4.
  - IDLE at cycle 5.
  - stall=1 for cycles 0-3, 0 at cycle 4.
- Store, d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF:
  - mem_en=mem_we=1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF for exactly one cycle.
  - d_ready pulses 3 cycles later.
  - d_rdata unchanged.
- Conflict, both requests high continuously from reset:
  - Grant order is data, fetch, data, fetch.
  - Ready pulses are spaced MEM_LAT+3=5 cycles apart.
- Back-to-back loads, d_req held high across d_ready, with d_addr changed to 0x104 the cycle after d_ready:
  - Second grant occurs in the IDLE cycle after DONE.
  - Exactly one ready per transaction; no duplicate access to 0x100.
- Reset asserted during WAIT of a fetch:
  - No if_ready.
  - All outputs 0 next cycle.
  - A subsequent conflict grants data first.
- MEM_LAT=1, load from 0x8 with mem_rdata=0x12345678 at cycle 2:
  - d_ready=1 and d_rdata=0x12345678 at cycle 3.
